subword_mem_ctrl: RTL and testbench

Sequencing controller between the CPU's load/store datapath and the word-wide synchronous data RAM. It runs every load and store as a short multi-cycle transaction. Byte and halfword stores are done as read-modify-write: read the word, merge the new data into the addressed lane, write the word back. Loads return the addressed lane sign- or zero-extended. The controller also stalls the CPU through a ready/valid request handshake.

---
 rtl/mem_ctrl_pkg.sv | 29 ++
 rtl/subword_lane_unit.sv | 49 ++++
 rtl/subword_mem_ctrl.sv | 129 ++++++++++++
 tb/tb_subword_mem_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the sub-word memory controller: request size codes,
// FSM state encoding and the alignment check used at request acceptance.
package mem_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   // Misaligned half/word accesses and the reserved size code are rejected.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/subword_lane_unit.sv
// Combinational lane logic: merges store data into the addressed lane of a
// read word and extracts/extends the addressed lane for loads.
// Ports: rdata (RAM word), wdata (right-justified store data), size, addr_lo,
//        is_unsigned (zero-extend loads) -> merged (RMW word), load_val.
module subword_lane_unit
   import mem_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        is_unsigned,
   output logic [31:0] merged,
   output logic [31:0] load_val
);

   logic [31:0] mask;
   logic [4:0]  shamt;
   logic [31:0] lane;

   // Lane mask and bit offset, little-endian.
   always_comb begin
      mask  = 32'hFFFF_FFFF;
      shamt = 5'd0;
      case (size)
         SZ_BYTE: begin
            mask  = 32'h0000_00FF;
            shamt = {addr_lo, 3'b000};
         end
         SZ_HALF: begin
            mask  = 32'h0000_FFFF;
            shamt = {addr_lo[1], 4'b0000};
         end
         default: ;
      endcase
   end

   // Merge and extract; word size degenerates to full replacement / passthrough.
   always_comb begin
      merged = (rdata & ~(mask << shamt)) | ((wdata & mask) << shamt);
      lane   = (rdata >> shamt) & mask;
      case (size)
         SZ_BYTE: load_val = is_unsigned ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
         SZ_HALF: load_val = is_unsigned ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: load_val = lane;
      endcase
   end

endmodule

// File: rtl/subword_mem_ctrl.sv
// Load/store sequencer between the CPU and a word-wide synchronous RAM.
// Sub-word stores are read-modify-write; loads return an extended lane.
// Ports: clk, rst_n (sync, active-low); CPU request req_* with req_ready;
//        one-cycle response rsp_valid/rsp_rdata/rsp_err; RAM port mem_*.
module subword_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int unsigned BA_W = ADDR_W + 2;

   state_t            state, state_nx;
   logic              we_q, uns_q, err_q;
   logic [1:0]        size_q;
   logic [BA_W-1:0]   addr_q;
   logic [31:0]       wr_q, res_q;
   logic [31:0]       merged, load_val;
   logic              accept, mis;

   // Byte-address bits above the RAM range are deliberately dropped.
   logic unused_addr_hi;
   assign unused_addr_hi = &{1'b0, req_addr[31:BA_W]};

   assign accept = (state == ST_IDLE) && req_valid;
   assign mis    = is_misaligned(req_size, req_addr[1:0]);

   subword_lane_unit u_lane (
      .rdata       (mem_rdata),
      .wdata       (wr_q),
      .size        (size_q),
      .addr_lo     (addr_q[1:0]),
      .is_unsigned (uns_q),
      .merged      (merged),
      .load_val    (load_val)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (mis)                                state_nx = ST_RESP;
               else if (req_we && req_size == SZ_WORD) state_nx = ST_WR;
               else                                    state_nx = ST_RD;
            end
         end
         ST_RD:   state_nx = ST_WAIT;
         ST_WAIT: state_nx = we_q ? ST_WR : ST_RESP;
         ST_WR:   state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // State-decoded outputs; RAM strobes are gated so reset can never write.
   always_comb begin
      req_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         ST_IDLE: req_ready = 1'b1;
         ST_RD:   mem_en    = rst_n;
         ST_WR: begin
            mem_en = rst_n;
            mem_we = rst_n;
         end
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Request latch, RMW write word and load result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         uns_q  <= 1'b0;
         err_q  <= 1'b0;
         size_q <= 2'b00;
         addr_q <= '0;
         wr_q   <= 32'h0;
         res_q  <= 32'h0;
      end else if (accept) begin
         we_q   <= req_we;
         uns_q  <= req_unsigned;
         err_q  <= mis;
         size_q <= req_size;
         addr_q <= req_addr[BA_W-1:0];
         wr_q   <= req_wdata;
         res_q  <= 32'h0;
      end else if (state == ST_WAIT) begin
         if (we_q) wr_q  <= merged;
         else      res_q <= load_val;
      end
   end

   assign mem_addr  = addr_q[BA_W-1:2];
   assign mem_wdata = wr_q;
   assign rsp_rdata = res_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Self-checking bench for subword_mem_ctrl: directed scenarios followed by
// randomized requests checked against a byte-addressed reference memory.
module tb_subword_mem_ctrl;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned NWORDS = 1 << ADDR_W;
   localparam int unsigned NBYTES = NWORDS * 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]        req_size;
   logic [31:0]       req_addr, req_wdata;
   logic              rsp_valid, rsp_err;
   logic [31:0]       rsp_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   subword_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Synchronous RAM with activity counters.
   logic [31:0] ram [0:NWORDS-1];
   logic        ram_clr;
   int          rd_cnt = 0, wr_cnt = 0, rsp_cnt = 0;

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < NWORDS; i++) ram[i] <= 32'h0;
      end else begin
         if (mem_en && !mem_we) begin
            mem_rdata <= ram[mem_addr];
            rd_cnt    <= rd_cnt + 1;
         end
         if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
         end
      end
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
   end

   // Reference memory as plain bytes.
   logic [7:0] ref_bytes [0:NBYTES-1];

   function automatic logic [31:0] ref_word(input int w);
      return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
   endfunction

   function automatic bit ref_mis(input logic [1:0] sz, input int ba);
      return (sz == 2'd3) || (sz == 2'd1 && ba % 2 != 0) || (sz == 2'd2 && ba % 4 != 0);
   endfunction

   function automatic int nbytes_of(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request, follow it to its response and check everything.
   task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit junk, output logic [31:0] rdata);
      int ba, n, lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
      bit m;
      logic [31:0] exp_rd_val;
      ba = int'(addr[ADDR_W+1:0]);
      m  = ref_mis(sz, ba);
      n  = nbytes_of(sz);
      exp_rd_val = 32'h0;
      if (!m && !we) begin
         for (int i = 0; i < n; i++) exp_rd_val[8*i +: 8] = ref_bytes[ba+i];
         if (!uns && exp_rd_val[8*n-1] && n < 4)
            for (int i = 8*n; i < 32; i++) exp_rd_val[i] = 1'b1;
      end
      if (m)            exp_lat = 1;
      else if (!we)     exp_lat = 3;
      else if (n == 4)  exp_lat = 2;
      else              exp_lat = 4;
      exp_rd = (!m && (!we || n < 4)) ? 1 : 0;
      exp_wr = (!m && we) ? 1 : 0;

      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      rd0 = rd_cnt; wr0 = wr_cnt;
      if (!m && we) for (int i = 0; i < n; i++) ref_bytes[ba+i] = wdata[8*i +: 8];
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = c;
            req_valid = 1'b0;
            break;
         end
         if (junk) begin
            req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
            req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         end else begin
            req_valid = 1'b0;
         end
      end
      rdata = rsp_rdata;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rsp_err", 32'(rsp_err), 32'(m));
      chk("rsp_rdata", rsp_rdata, exp_rd_val);
      chk("ram_reads", 32'(rd_cnt - rd0), 32'(exp_rd));
      chk("ram_writes", 32'(wr_cnt - wr0), 32'(exp_wr));
      chk("ram_word", ram[ba/4], ref_word(ba/4));
   endtask

   logic [31:0] r;
   int          w0, r0, q0;

   initial begin
      for (int i = 0; i < NBYTES; i++) ref_bytes[i] = 8'h0;
      rst_n = 1'b0; ram_clr = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1; ram_clr = 1'b0;

      // Preload via word stores.
      run_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h1122_3344, 1'b0, r);
      run_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h80FF_7F01, 1'b0, r);

      // Byte store merge.
      run_req(1'b1, 2'd0, 1'b0, 32'h2, 32'h0000_00AB, 1'b0, r);
      chk("sb_merge", ram[0], 32'h11AB_3344);

      // Byte loads.
      run_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 1'b0, r);
      chk("lb_6", r, 32'hFFFF_FFFF);
      run_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 1'b0, r);
      chk("lbu_7", r, 32'h0000_0080);
      run_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 1'b0, r);
      chk("lb_4", r, 32'h0000_0001);
      run_req(1'b0, 2'd0, 1'b0, 32'h5, 32'h0, 1'b0, r);
      chk("lb_5", r, 32'h0000_007F);

      // Half store/load.
      run_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000_BEEF, 1'b0, r);
      chk("sh_merge", ram[2], 32'hBEEF_0000);
      run_req(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, 1'b0, r);
      chk("lh_a", r, 32'hFFFF_BEEF);
      run_req(1'b0, 2'd1, 1'b1, 32'hA, 32'h0, 1'b0, r);
      chk("lhu_a", r, 32'h0000_BEEF);

      // Word store.
      run_req(1'b1, 2'd2, 1'b0, 32'hC, 32'hDEAD_BEEF, 1'b0, r);
      chk("sw_c", ram[3], 32'hDEAD_BEEF);

      // Misaligned and reserved-size requests.
      run_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 1'b0, r);
      run_req(1'b1, 2'd1, 1'b0, 32'h1, 32'h0000_5555, 1'b0, r);
      run_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h1234_5678, 1'b0, r);

      // Reset during WAIT of a byte store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h1; req_wdata = 32'h5A;
      w0 = wr_cnt; q0 = rsp_cnt;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("rmw_rst_mem_we", 32'(mem_we), 32'd0);
      chk("rmw_rst_mem_en", 32'(mem_en), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      chk("rmw_rst_ready", 32'(req_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("rmw_rst_ready2", 32'(req_ready), 32'd1);
      chk("rmw_rst_writes", 32'(wr_cnt - w0), 32'd0);
      chk("rmw_rst_rsp", 32'(rsp_cnt - q0), 32'd0);
      chk("rmw_rst_word", ram[0], 32'h11AB_3344);

      // Request presented while reset is held is dropped.
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
      r0 = rd_cnt; q0 = rsp_cnt;
      @(negedge clk); rst_n = 1'b1; req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstreq_reads", 32'(rd_cnt - r0), 32'd0);
      chk("rstreq_rsp", 32'(rsp_cnt - q0), 32'd0);

      // Randomized traffic over the low 16 words, with junk on the inputs while busy.
      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         a  = $urandom;
         a[ADDR_W+1:6] = '0;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         run_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
